// File: rtl/vpe_accum_rf.sv
// Vector accumulator register file: 32 x 64-bit entries fed by a two-stage op pipeline, plus a readout FSM.
// Optional macro VPE_ACC_SAT_EN makes the accumulate op saturate each lane instead of wrapping.
module vpe_accum_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] i_data,
  input  logic        i_data_v,
  input  logic        i_en_relu,
  input  logic [4:0]  i_rf_idx,
  input  logic [1:0]  i_rf_mux,
  input  logic        i_clr,
  input  logic        i_rd_start,
  input  logic [4:0]  i_rd_base,
  input  logic [5:0]  i_rd_len,
  input  logic        i_rd_ready,
  output logic [63:0] o_rd_data,
  output logic        o_rd_v,
  output logic        o_rd_busy,
  output logic        o_rd_done
);

  typedef enum logic [1:0] {IDLE, READ, DONE} rdState_e;

  logic [63:0] mem_q [32];
  logic [31:0] valid_q;

  logic        s1Valid_q;
  logic [1:0]  s1Op_q;
  logic [4:0]  s1Idx_q;
  logic [63:0] s1New_q;
  logic [63:0] s1Old_q;
  logic [63:0] s1Old_d;
  logic [63:0] reluData;
  logic [63:0] wrData;
  logic        wrEn;

  rdState_e    state_q, state_d;
  logic [4:0]  rdAddr_q, rdAddr_d;
  logic [5:0]  rdCnt_q, rdCnt_d;
  logic [63:0] rdData_q, rdData_d;
  logic        rdV_q, rdV_d;
  logic        rdAccept;
  logic [4:0]  loadAddr;
  logic [63:0] loadData;

  function automatic logic [7:0] laneOp(input logic [1:0] op, input logic [7:0] oldL,
                                        input logic [7:0] newL);
    logic [8:0] sum;
    logic [7:0] res;
    sum = {oldL[7], oldL} + {newL[7], newL};
    case (op)
      2'b01: begin
`ifdef VPE_ACC_SAT_EN
        if (sum[8] != sum[7]) res = sum[8] ? 8'h80 : 8'h7F;
        else                  res = sum[7:0];
`else
        res = sum[7:0];
`endif
      end
      2'b10:   res = ($signed(newL) > $signed(oldL)) ? newL : oldL;
      default: res = newL;
    endcase
    return res;
  endfunction

  always_comb begin
    reluData = '0;
    wrData   = '0;
    for (int k = 0; k < 8; k++) begin
      reluData[8*k +: 8] = (i_en_relu && i_data[8*k+7]) ? 8'h00 : i_data[8*k +: 8];
      wrData[8*k +: 8]   = laneOp(s1Op_q, s1Old_q[8*k +: 8], s1New_q[8*k +: 8]);
    end
  end

  // A clear or reset at this edge discards the stage-2 op, so it never writes.
  assign wrEn = s1Valid_q && (s1Op_q != 2'b11) && !i_clr && !rst;

  always_comb begin
    if (wrEn && (s1Idx_q == i_rf_idx)) s1Old_d = wrData;
    else if (valid_q[i_rf_idx])        s1Old_d = mem_q[i_rf_idx];
    else                               s1Old_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      s1Valid_q <= i_data_v && !i_clr;
      if (i_clr)     valid_q <= '0;
      else if (wrEn) valid_q[s1Idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    s1Op_q  <= i_rf_mux;
    s1Idx_q <= i_rf_idx;
    s1New_q <= reluData;
    s1Old_q <= s1Old_d;
    if (wrEn) mem_q[s1Idx_q] <= wrData;
  end

  // Readout beats see the same-edge stage-2 write and the same-edge clear.
  assign rdAccept = (state_q == READ) && rdV_q && i_rd_ready;
  assign loadAddr = rdAccept ? (rdAddr_q + 5'd1) : rdAddr_q;

  always_comb begin
    if (i_clr)                                loadData = '0;
    else if (wrEn && (s1Idx_q == loadAddr))   loadData = wrData;
    else if (valid_q[loadAddr])               loadData = mem_q[loadAddr];
    else                                      loadData = '0;
  end

  always_comb begin
    state_d  = state_q;
    rdAddr_d = rdAddr_q;
    rdCnt_d  = rdCnt_q;
    rdData_d = rdData_q;
    rdV_d    = rdV_q;
    case (state_q)
      IDLE: begin
        if (i_rd_start) begin
          rdAddr_d = i_rd_base;
          rdCnt_d  = i_rd_len;
          rdV_d    = 1'b0;
          state_d  = (i_rd_len == 6'd0) ? DONE : READ;
        end
      end
      READ: begin
        if (!rdV_q) begin
          rdData_d = loadData;
          rdV_d    = 1'b1;
        end else if (i_rd_ready) begin
          if (rdCnt_q == 6'd1) begin
            state_d  = DONE;
            rdV_d    = 1'b0;
            rdData_d = '0;
          end else begin
            rdAddr_d = loadAddr;
            rdCnt_d  = rdCnt_q - 6'd1;
            rdData_d = loadData;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rdAddr_q <= '0;
      rdCnt_q  <= '0;
      rdData_q <= '0;
      rdV_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdAddr_q <= rdAddr_d;
      rdCnt_q  <= rdCnt_d;
      rdData_q <= rdData_d;
      rdV_q    <= rdV_d;
    end
  end

  assign o_rd_data = rdData_q;
  assign o_rd_v    = rdV_q;
  assign o_rd_busy = (state_q != IDLE);
  assign o_rd_done = (state_q == DONE);

endmodule

// File: tb/tb_vpe_accum_rf.sv
// Self-checking bench for vpe_accum_rf: op table checked through single-entry readouts,
// then hand-written wrap/backpressure, clear-mid-readout and reset-mid-readout sequences.
module tb_vpe_accum_rf;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_data;
  logic        i_data_v;
  logic        i_en_relu;
  logic [4:0]  i_rf_idx;
  logic [1:0]  i_rf_mux;
  logic        i_clr;
  logic        i_rd_start;
  logic [4:0]  i_rd_base;
  logic [5:0]  i_rd_len;
  logic        i_rd_ready;
  logic [63:0] o_rd_data;
  logic        o_rd_v;
  logic        o_rd_busy;
  logic        o_rd_done;

  vpe_accum_rf dut (
    .clk        (clk),
    .rst        (rst),
    .i_data     (i_data),
    .i_data_v   (i_data_v),
    .i_en_relu  (i_en_relu),
    .i_rf_idx   (i_rf_idx),
    .i_rf_mux   (i_rf_mux),
    .i_clr      (i_clr),
    .i_rd_start (i_rd_start),
    .i_rd_base  (i_rd_base),
    .i_rd_len   (i_rd_len),
    .i_rd_ready (i_rd_ready),
    .o_rd_data  (o_rd_data),
    .o_rd_v     (o_rd_v),
    .o_rd_busy  (o_rd_busy),
    .o_rd_done  (o_rd_done)
  );

  always #5 clk = ~clk;

`ifdef VPE_ACC_SAT_EN
  localparam logic [63:0] ACC9EXP  = {8{8'h7F}};
  localparam logic [63:0] ACC14EXP = 64'h7F80_0000_7F80_7F81;
`else
  localparam logic [63:0] ACC9EXP  = {8{8'h90}};
  localparam logic [63:0] ACC14EXP = 64'h807F_0000_8080_8081;
`endif

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  idx;
    logic [63:0] data;
    logic        relu;
    logic        check;
    logic [63:0] exp;
  } vec_t;

  vec_t        vecs [14];
  logic [63:0] expQ [$];
  logic [63:0] shadow [32];
  int          testsRun = 0;
  int          testsFailed = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_data_v = 1'b0;
    repeat (n) step();
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] idx,
                               input logic [63:0] data, input logic relu);
    i_data_v  = 1'b1;
    i_rf_mux  = op;
    i_rf_idx  = idx;
    i_data    = data;
    i_en_relu = relu;
    step();
  endtask

  task automatic popCheck();
    if (expQ.size() == 0) begin
      checkOutput("extraBeat", o_rd_data, 64'hDEAD_DEAD_DEAD_DEAD);
    end else begin
      checkOutput("readBeat", o_rd_data, expQ.pop_front());
    end
  endtask

  // Start a readout, optionally toggle ready and poke a spurious start, then compare beats.
  task automatic runReadout(input logic [4:0] base, input logic [5:0] len,
                            input logic toggle, input logic poke);
    int beats = 0;
    int dones = 0;
    logic finished = 1'b0;
    logic held = 1'b0;
    logic [63:0] heldData = '0;
    i_rd_start = 1'b1;
    i_rd_base  = base;
    i_rd_len   = len;
    i_rd_ready = 1'b0;
    step();
    i_rd_start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (dones > 0 && !o_rd_busy) begin
        finished = 1'b1;
        break;
      end
      if (o_rd_done) dones++;
      if (held) checkOutput("beatStable", o_rd_data, heldData);
      i_rd_ready = toggle ? cyc[0] : 1'b1;
      i_rd_start = poke && (cyc == 3);
      i_rd_base  = poke ? 5'd5 : base;
      i_rd_len   = poke ? 6'd2 : len;
      if (o_rd_v && i_rd_ready) begin
        popCheck();
        beats++;
      end
      held     = o_rd_v && !i_rd_ready;
      heldData = o_rd_data;
      step();
    end
    i_rd_start = 1'b0;
    checkOutput("readoutFinished", 64'(finished), 64'd1);
    checkOutput("beatCount", 64'(beats), 64'(len));
    checkOutput("donePulses", 64'(dones), 64'd1);
    checkOutput("queueEmpty", 64'(expQ.size()), 64'd0);
    expQ.delete();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int beats;
    int dones;
    logic finished;
    logic clrPending;
    logic clrDone;
    logic [63:0] heldData;
    logic sawBad;

    vecs[0]  = '{2'b00, 5'd3,  {8{8'h05}},            1'b0, 1'b1, {8{8'h05}}};
    vecs[1]  = '{2'b00, 5'd0,  {8{8'hF0}},            1'b1, 1'b1, 64'h0};
    vecs[2]  = '{2'b10, 5'd0,  {8{8'h7F}},            1'b0, 1'b1, {8{8'h7F}}};
    vecs[3]  = '{2'b01, 5'd7,  {8{8'h01}},            1'b0, 1'b0, 64'h0};
    vecs[4]  = '{2'b01, 5'd7,  {8{8'h01}},            1'b0, 1'b0, 64'h0};
    vecs[5]  = '{2'b01, 5'd7,  {8{8'h01}},            1'b0, 1'b1, {8{8'h03}}};
    vecs[6]  = '{2'b00, 5'd9,  {8{8'h70}},            1'b0, 1'b0, 64'h0};
    vecs[7]  = '{2'b01, 5'd9,  {8{8'h20}},            1'b0, 1'b1, ACC9EXP};
    vecs[8]  = '{2'b00, 5'd12, 64'h807F_01FF_10F0_00C3, 1'b1, 1'b1, 64'h007F_0100_1000_0000};
    vecs[9]  = '{2'b10, 5'd12, 64'h0580_7FFF_2001_FE10, 1'b0, 1'b1, 64'h057F_7F00_2001_0010};
    vecs[10] = '{2'b11, 5'd12, {8{8'hFF}},            1'b0, 1'b1, 64'h057F_7F00_2001_0010};
    vecs[11] = '{2'b01, 5'd14, 64'h7F80_FF01_40C0_0101, 1'b0, 1'b1, 64'h7F80_FF01_40C0_0101};
    vecs[12] = '{2'b01, 5'd14, 64'h01FF_01FF_40C0_7F80, 1'b0, 1'b1, ACC14EXP};
    vecs[13] = '{2'b11, 5'd20, {8{8'h11}},            1'b0, 1'b1, 64'h0};

    rst = 1'b1; i_data = '0; i_data_v = 1'b0; i_en_relu = 1'b0; i_rf_idx = '0;
    i_rf_mux = '0; i_clr = 1'b0; i_rd_start = 1'b0; i_rd_base = '0; i_rd_len = '0;
    i_rd_ready = 1'b0;
    repeat (3) step();
    checkOutput("rstBusyDuring", 64'(o_rd_busy), 64'd0);
    rst = 1'b0;
    step();
    checkOutput("rstData", o_rd_data, 64'h0);
    checkOutput("rstValid", 64'(o_rd_v), 64'd0);
    checkOutput("rstBusy", 64'(o_rd_busy), 64'd0);
    checkOutput("rstDone", 64'(o_rd_done), 64'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].op, vecs[i].idx, vecs[i].data, vecs[i].relu);
      if (vecs[i].check) begin
        idle(2);
        expQ.push_back(vecs[i].exp);
        runReadout(vecs[i].idx, 6'd1, 1'b0, 1'b0);
      end
    end

    $display("[TB] zero-length readout");
    runReadout(5'd4, 6'd0, 1'b0, 1'b0);

    $display("[TB] wrap with backpressure");
    shadow[30] = 64'hA1A2_A3A4_A5A6_A7A8;
    shadow[31] = 64'hB1B2_B3B4_B5B6_B7B8;
    shadow[0]  = 64'hC1C2_C3C4_C5C6_C7C8;
    shadow[1]  = 64'h1122_3344_5566_7788;
    applyStimulus(2'b00, 5'd30, shadow[30], 1'b0);
    applyStimulus(2'b00, 5'd31, shadow[31], 1'b0);
    applyStimulus(2'b00, 5'd0,  shadow[0],  1'b0);
    applyStimulus(2'b00, 5'd1,  shadow[1],  1'b0);
    idle(3);
    expQ.push_back(shadow[30]);
    expQ.push_back(shadow[31]);
    expQ.push_back(shadow[0]);
    expQ.push_back(shadow[1]);
    runReadout(5'd30, 6'd4, 1'b1, 1'b1);

    $display("[TB] clear during readout");
    for (int k = 0; k < 8; k++) begin
      shadow[k] = {8{8'(8'h11 * (k + 1))}};
      applyStimulus(2'b00, 5'(k), shadow[k], 1'b0);
    end
    idle(3);
    for (int k = 0; k < 4; k++) expQ.push_back(shadow[k]);
    for (int k = 0; k < 4; k++) expQ.push_back(64'h0);
    i_rd_start = 1'b1; i_rd_base = 5'd0; i_rd_len = 6'd8; i_rd_ready = 1'b0;
    step();
    i_rd_start = 1'b0;
    beats = 0; dones = 0; finished = 1'b0; clrPending = 1'b0; clrDone = 1'b0; heldData = '0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (dones > 0 && !o_rd_busy) begin
        finished = 1'b1;
        break;
      end
      if (o_rd_done) dones++;
      i_clr = 1'b0;
      if (clrPending) begin
        checkOutput("clrHeldBeat", o_rd_data, heldData);
        clrPending = 1'b0;
        clrDone = 1'b1;
      end
      if (beats == 3 && !clrDone && o_rd_v) begin
        i_clr = 1'b1;
        i_rd_ready = 1'b0;
        heldData = o_rd_data;
        clrPending = 1'b1;
      end else begin
        i_rd_ready = (beats < 3) || clrDone;
      end
      if (o_rd_v && i_rd_ready) begin
        popCheck();
        beats++;
      end
      step();
    end
    i_clr = 1'b0;
    checkOutput("clrReadoutFinished", 64'(finished), 64'd1);
    checkOutput("clrBeatCount", 64'(beats), 64'd8);
    checkOutput("clrDonePulses", 64'(dones), 64'd1);
    checkOutput("clrQueueEmpty", 64'(expQ.size()), 64'd0);
    expQ.delete();

    $display("[TB] reset during readout");
    applyStimulus(2'b00, 5'd2, {8{8'h42}}, 1'b0);
    idle(3);
    i_rd_start = 1'b1; i_rd_base = 5'd2; i_rd_len = 6'd4; i_rd_ready = 1'b0;
    step();
    i_rd_start = 1'b0;
    step();
    checkOutput("preRstValid", 64'(o_rd_v), 64'd1);
    checkOutput("preRstBeat", o_rd_data, {8{8'h42}});
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("midRstBusy", 64'(o_rd_busy), 64'd0);
    checkOutput("midRstValid", 64'(o_rd_v), 64'd0);
    checkOutput("midRstData", o_rd_data, 64'h0);
    sawBad = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (o_rd_done || o_rd_busy || o_rd_v) sawBad = 1'b1;
      step();
    end
    checkOutput("noDoneAfterRst", 64'(sawBad), 64'd0);
    expQ.push_back(64'h0);
    runReadout(5'd2, 6'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
